memory_ram: RTL and testbench
=============================

Name: memory_ram

Overview:
- Single-port synchronous-write, asynchronous-read RAM, DEPTH x DATA_WIDTH (default 256 x 8).
- General-purpose scratch storage addressed by a host or controller.
- Enable qualifies every access; ReadWrite selects read (1) or write (0).
- Asynchronous active-high reset clears the whole array and the output.

Parameters:
- DATA_WIDTH, 8, width of DataIn, DataOut and of each word.
- ADDR_WIDTH, 8, width of Address.
- DEPTH, 256, number of words; must equal 2**ADDR_WIDTH.

Ports:
- Clock  input  1  rising-edge clock for writes.
- Reset  input  1  asynchronous, active-high; clears array and output.
- DataOut  output  DATA_WIDTH  read data.
- DataIn  input  DATA_WIDTH  write data.
- Address  input  ADDR_WIDTH  word address for read and write.
- Enable  input  1  access enable; no access when 0.
- ReadWrite  input  1  1 = read, 0 = write.
- Positional instantiation order: DataOut, DataIn, Address, Enable, ReadWrite, Clock, Reset.

Behaviour:
- Reset asserted, at any time without waiting for a clock edge:
  - all DEPTH words become 0;
  - DataOut = 0;
  - writes are blocked while Reset is high.
- Reset deasserted: normal operation from the next rising Clock edge.
- Write:
  - at a rising Clock edge with Enable=1 and ReadWrite=0, mem[Address] <= DataIn;
  - only one word changes per edge; all other words hold.
- Read (combinational, zero-cycle latency):
  - when Enable=1 and ReadWrite=1, DataOut = mem[Address];
  - DataOut follows Address changes within the same cycle.
- Idle:
  - when Enable=0, or during a write (ReadWrite=0), DataOut = 0;
  - no tri-state output.
- Read-after-write:
  - a word written at edge N is visible on DataOut as soon as ReadWrite=1 with the same Address after edge N;
  - no clock edge is needed for the read.
- Enable deasserted mid-cycle: DataOut returns to 0 immediately; stored contents are unaffected.
- Mode switching: toggling ReadWrite between edges causes no write. Only the values sampled at the rising edge decide a write.
- Address range: covers the full range 0..DEPTH-1; no out-of-range case exists and no wrap logic is needed.
- Reset priority: reset during an enabled write takes priority and the word is cleared, not written.
- Contents are retained indefinitely between accesses while Reset stays low.

Test Plan:
- Basic write/read:
  - Reset pulse, then Enable=1, ReadWrite=0, Address=0x00, DataIn=0x55, one rising edge.
  - Set ReadWrite=1 -> DataOut=0x55 before the next edge.
  - Drop Enable -> DataOut=0x00.
- Reset clears contents:
  - Write 0xA5 to 0x10, assert Reset between edges -> DataOut=0 at once.
  - After release, read 0x10 -> 0x00.
- Enable gating:
  - Enable=0, ReadWrite=0, Address=0x20, DataIn=0xFF, clock edge.
  - Then read 0x20 with Enable=1 -> 0x00 (no write occurred).
- Address independence and boundaries:
  - Write 0x01 to 0x00, 0x80 to 0x7F, 0xFE to 0xFF.
  - Read all three back -> exact values; read 0x40 -> 0x00.
- Combinational read tracking:
  - With Enable=1, ReadWrite=1, step Address 0x00 -> 0x7F -> 0xFF without clock edges.
  - DataOut follows 0x01 -> 0x80 -> 0xFE within each step.
- Overwrite and output during write:
  - Write 0x33 then 0xCC to 0x05 on consecutive edges.
  - DataOut=0 while ReadWrite=0; subsequent read -> 0xCC.

Source files
------------

// File: rtl/memory_ram.sv
// memory_ram: single-port RAM, DEPTH x DATA_WIDTH words.
// Writes are synchronous to the rising Clock edge.
// Reads are combinational, with zero-cycle latency.
// An asynchronous active-high Reset clears every word and forces DataOut to 0.
module memory_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  output logic [DATA_WIDTH-1:0] DataOut,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  Enable,
  input  logic                  ReadWrite,
  input  logic                  Clock,
  input  logic                  Reset
);

  // Storage array. DEPTH equals 2**ADDR_WIDTH, so every address is in range.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Decoded access strobes.
  logic wr_en;
  logic rd_en;

  // Classify the current access from Enable and ReadWrite.
  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (Enable) begin
      if (ReadWrite) begin
        rd_en = 1'b1;
      end else begin
        wr_en = 1'b1;
      end
    end else begin
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
  end

  // Array update.
  // Reset clears every word immediately and wins over a coincident write.
  // Otherwise only the addressed word is written.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[Address] <= DataIn;
    end
  end

  // Read mux.
  // DataOut follows Address within the same cycle while a read is enabled.
  // It is driven low when idle, during a write, and while Reset is asserted.
  always_comb begin
    DataOut = '0;
    if (Reset) begin
      DataOut = '0;
    end else if (rd_en) begin
      DataOut = mem[Address];
    end else begin
      DataOut = '0;
    end
  end

endmodule

// File: tb/tb_memory_ram.sv
// tb_memory_ram: directed self-checking bench for memory_ram.
module tb_memory_ram;

  logic [7:0] DataOut;
  logic [7:0] DataIn;
  logic [7:0] Address;
  logic       Enable;
  logic       ReadWrite;
  logic       Clock;
  logic       Reset;

  int compared;
  int mismatched;

  memory_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256)) dut (
    .DataOut  (DataOut),
    .DataIn   (DataIn),
    .Address  (Address),
    .Enable   (Enable),
    .ReadWrite(ReadWrite),
    .Clock    (Clock),
    .Reset    (Reset)
  );

  // Free-running 10 ns clock.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Present a write in the low clock phase, then let the next rising edge take it.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clock);
    Enable    = 1'b1;
    ReadWrite = 1'b0;
    Address   = a;
    DataIn    = d;
    @(posedge Clock);
    #1;
  endtask

  // Combinational read: no clock edge is involved.
  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    Enable    = 1'b1;
    ReadWrite = 1'b1;
    Address   = a;
    #1;
    check_val(tag, DataOut, exp);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Reset      = 1'b1;
    Enable     = 1'b1;
    ReadWrite  = 1'b1;
    Address    = 8'h00;
    DataIn     = 8'h00;
    #3;
    check_val("reset_out", DataOut, 8'h00);
    @(negedge Clock);
    Reset = 1'b0;

    // Basic write/read.
    do_write(8'h00, 8'h55);
    ReadWrite = 1'b1;
    #1;
    check_val("basic_read", DataOut, 8'h55);
    Enable = 1'b0;
    #1;
    check_val("basic_disable", DataOut, 8'h00);

    // Reset clears contents, asynchronously.
    do_write(8'h10, 8'hA5);
    do_read("pre_reset_read", 8'h10, 8'hA5);
    Reset = 1'b1;
    #1;
    check_val("async_reset_out", DataOut, 8'h00);
    @(negedge Clock);
    Reset = 1'b0;
    do_read("post_reset_read", 8'h10, 8'h00);
    do_read("post_reset_addr0", 8'h00, 8'h00);

    // Reset has priority over a coincident enabled write.
    @(negedge Clock);
    Enable    = 1'b1;
    ReadWrite = 1'b0;
    Address   = 8'h11;
    DataIn    = 8'h77;
    Reset     = 1'b1;
    @(posedge Clock);
    #1;
    @(negedge Clock);
    Reset = 1'b0;
    do_read("reset_priority", 8'h11, 8'h00);

    // Enable gating: no write while Enable is low.
    @(negedge Clock);
    Enable    = 1'b0;
    ReadWrite = 1'b0;
    Address   = 8'h20;
    DataIn    = 8'hFF;
    @(posedge Clock);
    #1;
    do_read("enable_gating", 8'h20, 8'h00);

    // Address independence and boundary addresses.
    do_write(8'h00, 8'h01);
    do_write(8'h7F, 8'h80);
    do_write(8'hFF, 8'hFE);
    do_read("bound_00", 8'h00, 8'h01);
    do_read("bound_7f", 8'h7F, 8'h80);
    do_read("bound_ff", 8'hFF, 8'hFE);
    do_read("unwritten_40", 8'h40, 8'h00);

    // Combinational read tracking, aligned so no edge falls between steps.
    @(negedge Clock);
    do_read("track_00", 8'h00, 8'h01);
    do_read("track_7f", 8'h7F, 8'h80);
    do_read("track_ff", 8'hFF, 8'hFE);

    // Overwrite on consecutive edges. DataOut stays 0 while writing.
    do_write(8'h05, 8'h33);
    check_val("out_during_write1", DataOut, 8'h00);
    do_write(8'h05, 8'hCC);
    check_val("out_during_write2", DataOut, 8'h00);
    do_read("overwrite_read", 8'h05, 8'hCC);

    // Mode switching between edges causes no write.
    @(negedge Clock);
    Enable    = 1'b1;
    ReadWrite = 1'b1;
    Address   = 8'h30;
    DataIn    = 8'h99;
    #1;
    ReadWrite = 1'b0;
    #1;
    check_val("toggle_out_low", DataOut, 8'h00);
    ReadWrite = 1'b1;
    @(posedge Clock);
    #1;
    check_val("toggle_no_write", DataOut, 8'h00);

    // Retention across idle cycles.
    Enable = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    check_val("idle_out", DataOut, 8'h00);
    do_read("retain_7f", 8'h7F, 8'h80);
    do_read("retain_05", 8'h05, 8'hCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
